// File: rtl/shift_right_iter.sv
// Iterative right shifter: moves the operand one bit per cycle, logical or arithmetic,
// through an IDLE -> SHIFT -> DONE sequence. The result is held after the operation completes.
module shift_right_iter #(
    parameter int DATA_LEN  = 32,
    parameter int SHAMT_LEN = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [DATA_LEN-1:0]  i_value,
    input  logic [SHAMT_LEN-1:0] i_shamt,
    input  logic                 i_arith,
    input  logic                 i_flush,
    output logic [DATA_LEN-1:0]  o_shifted,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SHAMT_LEN-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [DATA_LEN-1:0]  shifted_q, shifted_d;
    logic                 accept;

    function automatic logic [DATA_LEN-1:0] shr1(input logic [DATA_LEN-1:0] v,
                                                 input logic arith);
        return {arith & v[DATA_LEN-1], v[DATA_LEN-1:1]};
    endfunction

    // Start is honoured only in IDLE; flush overrides it.
    assign accept = (state_q == ST_IDLE) && i_start && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            shifted_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            shifted_q <= shifted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = (i_shamt != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == SHAMT_LEN'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        shifted_d = shifted_q;
        if (i_flush) begin
            cnt_d     = '0;
            shifted_d = '0;
        end else if (accept) begin
            cnt_d     = i_shamt;
            mode_d    = i_arith;
            shifted_d = i_value;
        end else if (state_q == ST_SHIFT) begin
            cnt_d     = cnt_q - SHAMT_LEN'(1);
            shifted_d = shr1(shifted_q, mode_q);
        end
    end

    // Done is decoded from state alone so a flush in the DONE cycle still shows the pulse.
    always_comb begin
        o_busy    = (state_q != ST_IDLE);
        o_done    = (state_q == ST_DONE);
        o_shifted = shifted_q;
    end

endmodule
